// File: rtl/fp32_pkg.sv
// Shared constants and FSM encoding for the fp32 post-normalisation stage.
package fp32_pkg;

    localparam int         FP32_MANT_W = 24;     // raw mantissa width incl. hidden bit
    localparam int         FP32_EXP_W  = 8;      // biased exponent width
    localparam logic [7:0] EXP_MAX     = 8'hFF;  // all-ones exponent: inf/NaN

    // state   | meaning
    // IDLE    | waiting for a raw sum, in_ready high
    // NORM    | normalising the latched mantissa, one shift per cycle
    // DONE    | packed result held until the consumer takes it
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fp32_pack.sv
// Combinational packer: builds the IEEE-754 word from sign/exponent/fraction
// and the special-case flags decided by the normaliser.
module fp32_pack
    import fp32_pkg::*;
#(
    parameter int MANT_W = FP32_MANT_W,
    parameter int EXP_W  = FP32_EXP_W
) (
    input  logic                      sign_i,
    input  logic [EXP_W-1:0]          exp_i,
    input  logic [MANT_W-2:0]         frac_i,
    input  logic                      zero_i,
    input  logic                      ovf_i,
    input  logic                      unf_i,
    output logic [EXP_W+MANT_W-1:0]   result_o
);

    // Zero drops the sign, underflow keeps it, overflow becomes signed infinity.
    always_comb begin
        result_o = {sign_i, exp_i, frac_i};
        if (zero_i) begin
            result_o = '0;
        end else if (unf_i) begin
            result_o = {sign_i, {(EXP_W+MANT_W-1){1'b0}}};
        end else if (ovf_i) begin
            result_o = {sign_i, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/post_normalise32.sv
// Post-adder normalisation stage: takes the raw {carry,sum} magnitude with its
// aligned exponent, normalises it one bit per cycle and packs an fp32 result.
module post_normalise32
    import fp32_pkg::*;
#(
    parameter int MANT_W = FP32_MANT_W,
    parameter int EXP_W  = FP32_EXP_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MANT_W-1:0]         sum_in,
    input  logic                      carry_in,
    input  logic [EXP_W-1:0]          exp_in,
    input  logic                      sign_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MANT_W-1:0]   result,
    output logic                      ovf,
    output logic                      unf
);

    // Exponent is carried with one extra bit so increments past EXP_MAX show up.
    localparam logic [EXP_W:0] EXP_MAX9 = {1'b0, EXP_MAX};
    localparam logic [EXP_W:0] EXP_ONE  = (EXP_W+1)'(1);

    state_t                     state_q, state_d;
    logic [MANT_W:0]            mant_q, mant_d, mant_rsh;
    logic [EXP_W:0]             exp_q, exp_d, exp_inc;
    logic                       sign_q, sign_d;
    logic [EXP_W+MANT_W-1:0]    result_q, result_d, pk_result;
    logic                       ovf_q, ovf_d, unf_q, unf_d;

    logic                       pk_zero, pk_ovf, pk_unf;
    logic [EXP_W-1:0]           pk_exp;
    logic [MANT_W-2:0]          pk_frac;

    assign mant_rsh = mant_q >> 1;
    assign exp_inc  = exp_q + EXP_ONE;

    fp32_pack #(
        .MANT_W (MANT_W),
        .EXP_W  (EXP_W)
    ) u_pack (
        .sign_i   (sign_q),
        .exp_i    (pk_exp),
        .frac_i   (pk_frac),
        .zero_i   (pk_zero),
        .ovf_i    (pk_ovf),
        .unf_i    (pk_unf),
        .result_o (pk_result)
    );

    // Next-state and datapath: classify the latched value once per NORM cycle.
    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        pk_exp   = exp_q[EXP_W-1:0];
        pk_frac  = mant_q[MANT_W-2:0];
        pk_zero  = 1'b0;
        pk_ovf   = 1'b0;
        pk_unf   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mant_d  = {carry_in, sum_in};
                    exp_d   = {1'b0, exp_in};
                    sign_d  = sign_in;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                state_d = ST_DONE;
                if (exp_q == EXP_MAX9) begin
                    // inf/NaN: pass the fraction straight through
                end else if (mant_q[MANT_W]) begin
                    mant_d  = mant_rsh;
                    exp_d   = exp_inc;
                    pk_exp  = exp_inc[EXP_W-1:0];
                    pk_frac = mant_rsh[MANT_W-2:0];
                    pk_ovf  = (exp_inc >= EXP_MAX9);
                end else if (mant_q == '0) begin
                    pk_zero = 1'b1;
                end else if (mant_q[MANT_W-1]) begin
                    // already normalised
                end else if (exp_q <= EXP_ONE) begin
                    // no denormals: flush to signed zero
                    pk_unf = 1'b1;
                end else begin
                    mant_d  = mant_q << 1;
                    exp_d   = exp_q - EXP_ONE;
                    state_d = ST_NORM;
                end
                if (state_d == ST_DONE) begin
                    result_d = pk_result;
                    ovf_d    = pk_ovf;
                    unf_d    = pk_unf;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; en low freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            mant_q   <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (en) begin
            state_q  <= state_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_post_normalise32.sv
// Bench for post_normalise32: directed corner cases plus random transactions
// checked against an arithmetic model of the normalisation rules.
module tb_post_normalise32;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] sum_in;
    logic        carry_in;
    logic [7:0]  exp_in;
    logic        sign_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        ovf;
    logic        unf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    post_normalise32 dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .carry_in  (carry_in),
        .exp_in    (exp_in),
        .sign_in   (sign_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: find the leading one, count the shifts needed and see whether
    // the exponent survives them; latency is shifts+1.
    function automatic void model(input logic c, input logic [23:0] s, input logic [7:0] e,
                                  input logic sg, output logic [31:0] r, output logic o,
                                  output logic u, output int lat);
        int m, ei, msb, k;
        o   = 1'b0;
        u   = 1'b0;
        lat = 1;
        m   = (int'(c) << 24) | int'(s);
        ei  = int'(e);
        if (e == 8'hFF) begin
            r = {sg, 8'hFF, s[22:0]};
        end else if (c) begin
            m  = m / 2;
            ei = ei + 1;
            if (ei >= 255) begin
                r = {sg, 8'hFF, 23'd0};
                o = 1'b1;
            end else begin
                r = {sg, ei[7:0], m[22:0]};
            end
        end else if (m == 0) begin
            r = 32'd0;
        end else begin
            msb = 0;
            for (int i = 0; i < 24; i++) if (((m >> i) & 1) == 1) msb = i;
            k = 23 - msb;
            if (k == 0 || ei - k >= 1) begin
                m   = m << k;
                r   = {sg, 8'(ei - k), m[22:0]};
                lat = k + 1;
            end else begin
                r   = {sg, 31'd0};
                u   = 1'b1;
                lat = ((ei > 1) ? ei - 1 : 0) + 1;
            end
        end
    endfunction

    task automatic run_txn(input logic c, input logic [23:0] s, input logic [7:0] e,
                           input logic sg, input int hold, input int freeze);
        logic [31:0] r;
        logic        o, u;
        int          lat, cnt;
        model(c, s, e, sg, r, o, u, lat);

        cnt = 0;
        while (!in_ready && cnt < 50) begin
            step();
            cnt++;
        end
        chk("idle_ready", 32'(in_ready), 32'd1);

        carry_in = c;
        sum_in   = s;
        exp_in   = e;
        sign_in  = sg;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("busy_ready", 32'(in_ready), 32'd0);

        if (freeze > 0) begin
            en        = 1'b0;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            repeat (freeze) step();
            chk("frz_norm_valid", 32'(out_valid), 32'd0);
            chk("frz_norm_ready", 32'(in_ready), 32'd0);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            en        = 1'b1;
        end

        cnt = 0;
        while (cnt < 40) begin
            step();
            cnt++;
            if (out_valid) break;
        end
        chk("latency", 32'(cnt), 32'(lat));
        chk("result", result, r);
        chk("ovf", 32'(ovf), 32'(o));
        chk("unf", 32'(unf), 32'(u));

        repeat (hold) begin
            step();
            chk("hold_result", result, r);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
        end

        if (freeze > 0) begin
            en        = 1'b0;
            out_ready = 1'b1;
            step();
            step();
            chk("frz_done_valid", 32'(out_valid), 32'd1);
            chk("frz_done_result", result, r);
            out_ready = 1'b0;
            en        = 1'b1;
        end

        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic        c, sg;
        logic [23:0] s;
        logic [7:0]  e;

        rst       = 1'b0;
        en        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        carry_in  = 1'b0;
        sum_in    = '0;
        exp_in    = '0;
        sign_in   = 1'b0;

        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_unf", 32'(unf), 32'd0);
        rst = 1'b1;
        step();
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // Directed corner cases
        run_txn(1'b0, 24'h400000, 8'h80, 1'b0, 0, 0);   // one left shift -> 1.0
        run_txn(1'b1, 24'h800000, 8'h7F, 1'b0, 1, 0);   // carry -> 3.0
        run_txn(1'b1, 24'h800000, 8'hFE, 1'b1, 0, 0);   // carry into -inf
        run_txn(1'b0, 24'h000001, 8'h05, 1'b0, 0, 0);   // runs out of exponent
        run_txn(1'b0, 24'h000000, 8'h80, 1'b1, 0, 0);   // zero, sign dropped
        run_txn(1'b0, 24'h123456, 8'hFF, 1'b1, 0, 0);   // special passthrough
        run_txn(1'b0, 24'h000001, 8'h80, 1'b0, 0, 0);   // 23 shifts
        run_txn(1'b0, 24'h000100, 8'h80, 0, 5, 0);      // consumer stalls 5 cycles
        run_txn(1'b0, 24'h000100, 8'h40, 1, 2, 4);      // en frozen in NORM and DONE

        // Reset during the third NORM shift
        carry_in = 1'b0;
        sum_in   = 24'h000001;
        exp_in   = 8'h80;
        sign_in  = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        #2 rst = 1'b0;
        #1;
        chk("mid_norm_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_norm_rst_result", result, 32'd0);
        chk("mid_norm_rst_ovf", 32'(ovf), 32'd0);
        chk("mid_norm_rst_unf", 32'(unf), 32'd0);
        chk("mid_norm_rst_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        step();
        chk("after_rst_ready", 32'(in_ready), 32'd1);
        run_txn(1'b0, 24'h400000, 8'h80, 1'b0, 0, 0);

        // Reset while a non-zero result is held in DONE
        carry_in = 1'b0;
        sum_in   = 24'h800000;
        exp_in   = 8'h10;
        sign_in  = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("pre_done_rst_result", result, 32'h88000000);
        #2 rst = 1'b0;
        #1;
        chk("mid_done_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_done_rst_result", result, 32'd0);
        rst = 1'b1;
        step();

        // Random transactions over a spread of leading-one positions and exponents
        for (int i = 0; i < 60; i++) begin
            c  = ($urandom_range(0, 3) == 0);
            s  = 24'($urandom) >> $urandom_range(0, 23);
            sg = 1'($urandom);
            case ($urandom_range(0, 9))
                0:       e = 8'hFF;
                1:       e = 8'hFE;
                2:       e = 8'($urandom_range(0, 4));
                default: e = 8'($urandom_range(1, 254));
            endcase
            run_txn(c, s, e, sg, int'($urandom_range(0, 2)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/post_normalise32.md
POST_NORMALISE32 -- requirements
Module: post_normalise32

Interface
REQ-001 SHALL have parameter MANT_W, default 24, meaning the raw mantissa width including the hidden bit.
REQ-002 SHALL have parameter EXP_W, default 8, meaning the biased exponent width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port en  input  1  stage enable; when low the FSM and all registers hold.
REQ-006 SHALL have port in_valid  input  1  raw sum presented.
REQ-007 SHALL have port in_ready  output  1  stage can accept; high only in IDLE.
REQ-008 SHALL have port sum_in  input  24  raw mantissa from the adder stage.
REQ-009 SHALL have port carry_in  input  1  adder carry-out; the true magnitude is {carry_in,sum_in}.
REQ-010 SHALL have port exp_in  input  8  common aligned exponent.
REQ-011 SHALL have port sign_in  input  1  result sign.
REQ-012 SHALL have port out_valid  output  1  result held and valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port result  output  32  packed IEEE-754 single.
REQ-015 SHALL have port ovf  output  1  overflow to infinity; valid with out_valid.
REQ-016 SHALL have port unf  output  1  underflow flushed to zero; valid with out_valid.

Function
REQ-017 SHALL implement the FSM states IDLE, NORM and DONE.
REQ-018 SHALL accept when in_valid&&in_ready&&en, latching the mantissa (25 bits), exponent and sign, and moving IDLE->NORM.
REQ-019 SHALL, in NORM with exp==0xFF, go to DONE and produce {sign,0xFF,mant[22:0]} (special passthrough).
REQ-020 SHALL, in NORM with carry set, shift the mantissa right 1 and increment exp in the same cycle, then go to DONE; if the new exp is 0xFF, produce {sign,0xFF,0} with ovf=1.
REQ-021 SHALL, in NORM with a mantissa of 0, go to DONE and produce 0x00000000 regardless of sign.
REQ-022 SHALL, in NORM with mant[23]=1, go to DONE and produce {sign,exp,mant[22:0]}.
REQ-023 SHALL, otherwise in NORM, shift left 1 and decrement exp per cycle, staying in NORM; if exp==1 before the shift, go to DONE with result {sign,0,0} and unf=1 (no denormals).
REQ-024 SHALL complete normalisation in at most 23 shift cycles; latency is (k+1) cycles from the accept edge to out_valid, where k is the number of left shifts (k=0 for the carry, zero, normalised and special cases).
REQ-025 SHALL hold result, ovf and unf stable in DONE while out_ready is low.
REQ-026 SHALL, on out_ready in DONE, drop out_valid and return to IDLE; the earliest next accept is the following cycle.
REQ-027 SHALL have en low freeze state, shift count and outputs, ignoring in_valid and out_ready.
REQ-028 SHALL perform all exponent arithmetic in 9 bits internally so wrap-around is detectable.

Reset
REQ-029 SHALL, on rst low, asynchronously force IDLE, out_valid=0, result=0, ovf=0, unf=0 and clear the internal registers, including mid-NORM and mid-DONE.
REQ-030 SHALL drive in_ready high in the first cycle after rst is released.

Structure
REQ-031 SHALL place the FSM state encoding, EXP_MAX (0xFF) and MANT_W/EXP_W constants in the shared fp32 package.
REQ-032 SHALL use one sub-module, fp32_pack, a combinational packer of sign/exp/mantissa/flags into result.

Verification
REQ-033 SHALL cover: sum_in=0x400000, carry 0, exp 0x80, sign 0 -> result 0x3F800000, out_valid 2 cycles after accept, ovf=unf=0.
REQ-034 SHALL cover: sum_in=0x800000, carry 1, exp 0x7F -> result 0x40400000, out_valid 1 cycle after accept.
REQ-035 SHALL cover: carry 1, exp 0xFE, sign 1 -> result 0xFF800000, ovf=1.
REQ-036 SHALL cover: sum_in=0x000001, exp 0x05 -> result 0x00000000, unf=1; and sum_in=0 -> result 0x00000000 after 1 cycle.
REQ-037 SHALL cover: out_ready held low 5 cycles in DONE -> result stable, in_ready low; out_ready high -> IDLE the next cycle.
REQ-038 SHALL cover: rst asserted during the 3rd NORM shift -> immediate IDLE, outputs 0; a fresh 0x400000/0x80 input then yields 0x3F800000.
